// File: rtl/pipe_rotator_pkg.sv
// Shared types for the pipelined rotator/shifter: operation mode encoding.
package pipe_rotator_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_ROR = 2'b00,
        MODE_ROL = 2'b01,
        MODE_SRL = 2'b10,
        MODE_SRA = 2'b11
    } rot_mode_e;

endpackage

// File: rtl/pipe_rotator_stage.sv
// One barrel level: displaces the beat by 2**LEVEL when its amount bit is set, then registers
// it behind a valid/load handshake. Flag ports exist only with PIPE_ROTATOR_FLAGS_EN.
module pipe_rotator_stage
    import pipe_rotator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LOG2W = 5,
    parameter int LEVEL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic [LOG2W-1:0] up_amount,
    input  rot_mode_e        up_mode,
`ifdef PIPE_ROTATOR_FLAGS_EN
    input  logic             up_carry,
    output logic             dn_carry,
    output logic             dn_zero,
`endif
    input  logic             dn_load,
    output logic             load,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    output logic [LOG2W-1:0] dn_amount,
    output rot_mode_e        dn_mode
);

    localparam int SHIFT = 1 << LEVEL;

    logic [WIDTH-1:0] shifted;

    always_comb begin
        // NOTE: default assignment first so every path drives shifted; no latch is inferred.
        shifted = up_data;
        if (up_amount[LEVEL]) begin
            case (up_mode)
                MODE_ROR: shifted = (up_data >> SHIFT) | (up_data << (WIDTH - SHIFT));
                MODE_ROL: shifted = (up_data << SHIFT) | (up_data >> (WIDTH - SHIFT));
                MODE_SRL: shifted = up_data >> SHIFT;
                MODE_SRA: shifted = $signed(up_data) >>> SHIFT;
                default:  shifted = up_data;
            endcase
        end
    end

    // A full stage may refill only while its contents move on the same edge.
    assign load = !dn_valid || dn_load;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for all registered state so stages update together.
        if (rst) begin
            dn_valid  <= 1'b0;
            dn_data   <= '0;
            dn_amount <= '0;
            dn_mode   <= MODE_ROR;
`ifdef PIPE_ROTATOR_FLAGS_EN
            dn_carry  <= 1'b0;
            dn_zero   <= 1'b0;
`endif
        end else if (load) begin
            dn_valid  <= up_valid;
            dn_data   <= shifted;
            dn_amount <= up_amount;
            dn_mode   <= up_mode;
`ifdef PIPE_ROTATOR_FLAGS_EN
            dn_carry  <= up_carry;
            dn_zero   <= (shifted == '0);
`endif
        end
    end

endmodule

// File: rtl/pipe_rotator.sv
// Pipelined rotate/shift unit: LOG2W registered barrel levels with elastic valid/ready flow.
// Define PIPE_ROTATOR_FLAGS_EN to add the out_zero and out_carry flag outputs.
module pipe_rotator
    import pipe_rotator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LOG2W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [LOG2W-1:0]   in_amount,
    input  logic [MODE_W-1:0]  in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
`ifdef PIPE_ROTATOR_FLAGS_EN
    ,
    output logic               out_zero,
    output logic               out_carry
`endif
);

    logic [LOG2W:0]   valid;
    logic [LOG2W:0]   load;
    logic [WIDTH-1:0] data   [LOG2W+1];
    logic [LOG2W-1:0] amount [LOG2W+1];
    rot_mode_e        mode   [LOG2W+1];

    assign valid[0]      = in_valid;
    assign data[0]       = in_data;
    assign amount[0]     = in_amount;
    assign mode[0]       = rot_mode_e'(in_mode);
    assign load[LOG2W]   = out_ready;
    assign in_ready      = load[0];
    assign out_valid     = valid[LOG2W];
    assign out_data      = data[LOG2W];

    logic unused_tail;
    assign unused_tail = ^{amount[LOG2W], mode[LOG2W]};

`ifdef PIPE_ROTATOR_FLAGS_EN
    logic [LOG2W:0]   carry;
    logic [LOG2W-1:0] zero;
    logic [LOG2W-1:0] carry_idx;
    logic             unused_zero;

    // The last bit shifted out is known from the original operand, so it is picked once here.
    assign carry_idx = (mode[0] == MODE_ROL) ? (LOG2W'(0) - in_amount) : (in_amount - LOG2W'(1));
    assign carry[0]  = (in_amount != '0) && in_data[carry_idx];
    assign out_carry = carry[LOG2W];
    assign out_zero  = zero[LOG2W-1];
    assign unused_zero = ^zero[LOG2W-2:0];
`endif

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        pipe_rotator_stage #(
            .WIDTH (WIDTH),
            .LOG2W (LOG2W),
            .LEVEL (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .up_valid  (valid[k]),
            .up_data   (data[k]),
            .up_amount (amount[k]),
            .up_mode   (mode[k]),
`ifdef PIPE_ROTATOR_FLAGS_EN
            .up_carry  (carry[k]),
            .dn_carry  (carry[k+1]),
            .dn_zero   (zero[k]),
`endif
            .dn_load   (load[k+1]),
            .load      (load[k]),
            .dn_valid  (valid[k+1]),
            .dn_data   (data[k+1]),
            .dn_amount (amount[k+1]),
            .dn_mode   (mode[k+1])
        );
    end

endmodule

// File: tb/tb_pipe_rotator.sv
// Scoreboard bench for pipe_rotator at WIDTH=32: directed beats, mixed stream, stall and reset.
module tb_pipe_rotator;
    import pipe_rotator_pkg::*;

    localparam int W  = 32;
    localparam int LW = 5;

    typedef struct {
        logic [W-1:0] data;
        logic         zero;
        logic         carry;
        int           acc;
        bit           chk_lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [LW-1:0] in_amount = '0;
    rot_mode_e     in_mode = MODE_ROR;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
`ifdef PIPE_ROTATOR_FLAGS_EN
    logic          out_zero;
    logic          out_carry;
`endif

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    pipe_rotator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amount (in_amount),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_ROTATOR_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_carry (out_carry)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] d, input logic z, input logic c);
        exp_t e;
        e.data = d; e.zero = z; e.carry = c; e.acc = 0; e.chk_lat = 1'b0;
        return e;
    endfunction

    // Bit-by-bit reference taken straight from the operation definitions.
    function automatic exp_t model(input logic [W-1:0] d, input int a, input rot_mode_e m);
        exp_t e;
        e = mk('0, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) begin
            case (m)
                MODE_ROR: e.data[i] = d[(i + a) % W];
                MODE_ROL: e.data[i] = d[(i - a + W) % W];
                MODE_SRL: e.data[i] = (i + a < W) ? d[(i + a) % W] : 1'b0;
                default:  e.data[i] = (i + a < W) ? d[(i + a) % W] : d[W-1];
            endcase
        end
        e.zero  = (e.data == '0);
        e.carry = (a == 0) ? 1'b0 : ((m == MODE_ROL) ? d[W - a] : d[a - 1]);
        return e;
    endfunction

    // Output side of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", W'(out_valid), W'(1'b0));
            end else begin
                mon_e = sb.pop_front();
                check("out_data", out_data, mon_e.data);
`ifdef PIPE_ROTATOR_FLAGS_EN
                check("out_zero", W'(out_zero), W'(mon_e.zero));
                check("out_carry", W'(out_carry), W'(mon_e.carry));
`endif
                if (mon_e.chk_lat) check("latency", W'(cyc - mon_e.acc), W'(LW));
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [LW-1:0] a, input rot_mode_e m,
                        input exp_t e, input bit chk);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_amount = a; in_mode = m;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", W'(in_ready), W'(1'b1));
        end else begin
            e.acc = cyc; e.chk_lat = chk;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [W-1:0] d, input logic [LW-1:0] a, input rot_mode_e m,
                              input bit chk);
        send(d, a, m, model(d, int'(a), m), chk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        check("drain", W'(sb.size()), W'(0));
    endtask

    initial begin : stim
        exp_t e;
        int   accepted;
        bit   have_hold;
        logic [W-1:0] hold;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_in_ready", W'(in_ready), W'(1'b1));
        check("rst_out_data", out_data, '0);
`ifdef PIPE_ROTATOR_FLAGS_EN
        check("rst_out_zero", W'(out_zero), W'(1'b0));
        check("rst_out_carry", W'(out_carry), W'(1'b0));
`endif
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Directed operations with hand-derived results.
        send(32'h8000_0001, 5'd1,  MODE_ROR, mk(32'hC000_0000, 1'b0, 1'b1), 1'b1);
        send(32'h8000_0001, 5'd4,  MODE_ROL, mk(32'h0000_0018, 1'b0, 1'b0), 1'b1);
        send(32'h8000_0000, 5'd31, MODE_SRL, mk(32'h0000_0001, 1'b0, 1'b0), 1'b1);
        send(32'h8000_0000, 5'd31, MODE_SRA, mk(32'hFFFF_FFFF, 1'b0, 1'b0), 1'b1);
        send(32'h0000_0000, 5'd7,  MODE_SRL, mk(32'h0000_0000, 1'b1, 1'b0), 1'b1);
        send(32'hA5C3_0F96, 5'd0,  MODE_ROR, mk(32'hA5C3_0F96, 1'b0, 1'b0), 1'b1);
        send(32'hA5C3_0F96, 5'd0,  MODE_ROL, mk(32'hA5C3_0F96, 1'b0, 1'b0), 1'b1);
        send(32'hA5C3_0F96, 5'd0,  MODE_SRL, mk(32'hA5C3_0F96, 1'b0, 1'b0), 1'b1);
        send(32'hA5C3_0F96, 5'd0,  MODE_SRA, mk(32'hA5C3_0F96, 1'b0, 1'b0), 1'b1);
        wait_drain();

        // Back-to-back stream, every amount, rotating through the modes.
        for (int a = 0; a < W; a++)
            send_model($urandom | 32'h8000_0000 * (a % 2), LW'(a), rot_mode_e'(a % 4), 1'b1);
        wait_drain();

        // Output stall with the producer always offering a beat.
        out_ready = 1'b0;
        accepted  = 0;
        have_hold = 1'b0;
        hold      = '0;
        in_valid  = 1'b1;
        in_data   = $urandom; in_amount = LW'($urandom); in_mode = rot_mode_e'($urandom_range(0, 3));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (have_hold) check("stall_hold", out_data, hold);
            else if (out_valid) begin hold = out_data; have_hold = 1'b1; end
            if (in_ready) begin
                e = model(in_data, int'(in_amount), in_mode);
                e.acc = cyc; e.chk_lat = 1'b0;
                sb.push_back(e);
                accepted++;
            end
            @(posedge clk); #1;
            in_data = $urandom; in_amount = LW'($urandom); in_mode = rot_mode_e'($urandom_range(0, 3));
        end
        @(negedge clk);
        check("stall_accepted", W'(accepted), W'(LW));
        check("stall_in_ready", W'(in_ready), W'(1'b0));
        check("stall_out_valid", W'(out_valid), W'(1'b1));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Reset with beats in flight.
        out_ready = 1'b0;
        send_model(32'h1234_5678, 5'd3,  MODE_ROR, 1'b0);
        send_model(32'h9ABC_DEF0, 5'd9,  MODE_SRA, 1'b0);
        send_model(32'h0F0F_0F0F, 5'd17, MODE_ROL, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("preflush_out_valid", W'(out_valid), W'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        check("flush_out_valid", W'(out_valid), W'(1'b0));
        check("flush_in_ready", W'(in_ready), W'(1'b1));
        check("flush_out_data", out_data, '0);
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        send_model(32'hDEAD_BEEF, 5'd12, MODE_SRL, 1'b1);
        wait_drain();
        repeat (10) @(posedge clk);
        #1;
        check("post_flush_idle", W'(out_valid), W'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_rotator.md
PIPE_ROTATOR -- requirements
Module: pipe_rotator

Interface
REQ-001 Parameter WIDTH, default 32, sets the datapath width; legal values are powers of two from 8 to 128.
REQ-002 Parameter LOG2W, default $clog2(WIDTH), sets the amount width and the pipeline depth; it is derived and not overridden.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: the input beat is valid.
REQ-006 Port in_ready, output, 1 bit: stage 0 accepts a beat this cycle.
REQ-007 Port in_data, input, WIDTH bits: the operand.
REQ-008 Port in_amount, input, LOG2W bits: the shift or rotate distance, 0 to WIDTH-1.
REQ-009 Port in_mode, input, 2 bits: 00 ROR, 01 ROL, 10 SRL (logical right), 11 SRA (arithmetic right).
REQ-010 Port out_valid, output, 1 bit: the result beat is valid.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 Port out_data, output, WIDTH bits: the result.

Function
REQ-013 The block SHALL implement LOG2W mux levels; level k applies a 2^k displacement when amount bit k is set, and each level SHALL be registered.
REQ-014 Latency SHALL be exactly LOG2W cycles from an accepted input (in_valid & in_ready) to out_valid when there is no stall (5 cycles for WIDTH=32).
REQ-015 ROR: out_data[i] = in_data[(i+amount) mod WIDTH]. ROL: out_data[i] = in_data[(i-amount) mod WIDTH].
REQ-016 SRL fills vacated MSBs with 0; SRA fills them with in_data[WIDTH-1].
REQ-017 Amount 0 SHALL pass in_data unchanged in all modes.
REQ-018 Each stage holds a valid bit, data, the remaining amount bits and the mode.
REQ-019 Stage k loads when it is empty or stage k+1 loads; the last stage loads when it is empty or out_ready=1.
REQ-020 in_ready SHALL equal the stage-0 load condition and SHALL be combinational, with no dependency on in_valid.
REQ-021 With out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable, and upstream bubbles SHALL collapse.
REQ-022 Full throughput is one beat per cycle while out_ready=1; beat order is preserved and no beat is dropped or duplicated.
REQ-023 The mode and amount of each beat travel with it, so mixed modes in flight are independent.

Reset
REQ-024 When rst is asserted, all stage valid bits SHALL clear asynchronously, giving out_valid=0 and in_ready=1.
REQ-025 During reset, data registers SHALL clear to 0, giving out_data=0.
REQ-026 Beats in flight when reset asserts mid-operation are discarded; the first beat accepted after release emerges LOG2W cycles later.

Configuration
REQ-027 With macro PIPE_ROTATOR_FLAGS_EN defined, the block SHALL add output out_zero (1 bit, out_data==0) and output out_carry (1 bit), both pipelined with their beat.
REQ-028 out_carry is the last bit displaced out: the bit at index amount-1 for ROR/SRL/SRA and the bit at index WIDTH-amount for ROL, taken from the original operand; it is 0 when amount is 0.
REQ-029 Both flags SHALL reset to 0.
REQ-030 Without PIPE_ROTATOR_FLAGS_EN, neither port nor its logic SHALL exist.

Structure
REQ-031 Package pipe_rotator_pkg SHALL hold the mode enum (ROR, ROL, SRL, SRA) and the 2-bit mode width constant.
REQ-032 Sub-module pipe_rotator_stage SHALL implement one mux level plus its handshake register; the top generates LOG2W instances.

Verification (WIDTH=32)
REQ-033 ROR 0x80000001 by 1 -> 0xC0000000 five cycles after acceptance; with flags, carry=1 and zero=0.
REQ-034 ROL 0x80000001 by 4 -> 0x00000018; SRL 0x80000000 by 31 -> 0x00000001; SRA 0x80000000 by 31 -> 0xFFFFFFFF.
REQ-035 Back-to-back beats with amounts 0..31 in mixed modes and out_ready=1 -> 32 results in order at one per cycle, matching a reference model.
REQ-036 Hold out_ready=0 for 10 cycles with in_valid=1 -> exactly 5 beats accepted and in_ready=0; out_data stays stable; release -> all 5 beats drain in order.
REQ-037 Assert rst with 3 beats in flight -> out_valid=0 immediately and those beats are never output; a beat sent after release appears 5 cycles later.
REQ-038 SRL 0x00000000 by 7 -> 0x00000000 with zero=1 and carry=0; amount 0 in every mode -> the operand unchanged.
